// File: rtl/alu_arb_ctrl.sv
// rtl/alu_arb_ctrl.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arb_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [5:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [5:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [5:0]   alu_signal,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         ptr_q, ptr_d;
  logic [5:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         id_q, id_d;
  logic [W-1:0] data_q, data_d;
  logic         err_q, err_d;

  logic         grant0, grant1;
  logic [5:0]   sel_op;
  logic [W-1:0] sel_a, sel_b;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'b100100, 6'b100101, 6'b100000,
      6'b100010, 6'b101010, 6'b000010: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

  // Grants are gated by rst_n so ready stays low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          op_d = sel_op;
          a_d  = sel_a;
          b_d  = sel_b;
          id_d = grant1;
          if (op_legal(sel_op)) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_RESP;
            data_d  = '0;
            err_d   = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        data_d  = alu_result;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Priority flips only once the granted response is consumed.
        if (rsp_ready) begin
          state_d = ST_IDLE;
          ptr_d   = ~id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign alu_signal = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb/tb_alu_arb_ctrl.sv - scoreboard bench for alu_arb_ctrl with a behavioural ALU and arbiter model
module tb_alu_arb_ctrl;
  localparam int W = 32;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_SLT = 6'b101010;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef struct { logic [5:0] op; logic [W-1:0] a; logic [W-1:0] b; } req_t;
  typedef struct { logic id; logic [W-1:0] data; logic err; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0] req0_op, req1_op, alu_signal;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_result;

  alu_arb_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_signal(alu_signal), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  req_t q0[$];
  req_t q1[$];
  rsp_t expq[$];
  bit got0 = 0, got1 = 0;
  bit withdraw_en = 0, rsp_rand = 0, rsp_fixed = 1;

  // Reference timeline: busy from acceptance until the response is consumed.
  bit m_busy = 0, m_ptr = 0, m_in_exec = 0;
  int m_wait = 0;
  req_t m_cur;
  bit m_cur_id;
  bit prev_valid = 0, prev_hs = 0, prev_id = 0, prev_err = 0;
  logic [W-1:0] prev_data = '0;

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL};
  endfunction

  function automatic logic [W-1:0] alu_fn(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SRL:  return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_signal, alu_a, alu_b);

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rsp_valid"}, W'(rsp_valid), '0);
    check({tag, "_rsp_id"}, W'(rsp_id), '0);
    check({tag, "_rsp_err"}, W'(rsp_err), '0);
    check({tag, "_rsp_data"}, rsp_data, '0);
    check({tag, "_alu_signal"}, W'(alu_signal), '0);
    check({tag, "_alu_a"}, alu_a, '0);
    check({tag, "_alu_b"}, alu_b, '0);
    check({tag, "_req0_ready"}, W'(req0_ready), '0);
    check({tag, "_req1_ready"}, W'(req1_ready), '0);
  endtask

  function automatic req_t mk(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_busy) && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (c >= budget) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d cycles required under %0d", tag, c, budget);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_ptr = 0; m_in_exec = 0;
    prev_valid = 0; prev_hs = 0;
    expq.delete();
  endtask

  // Driver: retire accepted requests, then present queue heads (optionally withdrawn at random).
  initial begin
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    forever begin
      @(posedge clk); #2;
      if (got0) begin q0.delete(0); got0 = 0; end
      if (got1) begin q1.delete(0); got1 = 0; end
      req0_valid = (q0.size() != 0) && !(withdraw_en && $urandom_range(99) < 30);
      req1_valid = (q1.size() != 0) && !(withdraw_en && $urandom_range(99) < 30);
      if (req0_valid) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
      else begin req0_op = 6'($urandom); req0_a = $urandom; req0_b = $urandom; end
      if (req1_valid) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
      else begin req1_op = 6'($urandom); req1_a = $urandom; req1_b = $urandom; end
      rsp_ready = rsp_rand ? ($urandom_range(99) < 60) : rsp_fixed;
    end
  end

  // Monitor: compares grants, response timing/stability and pops the scoreboard on each handshake.
  initial begin
    bit exp0, exp1, exp_v;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp0 = !m_busy && req0_valid && (!req1_valid || !m_ptr);
        exp1 = !m_busy && req1_valid && !exp0;
        exp_v = m_busy && (m_wait == 0);
        m_in_exec = m_busy && (m_wait == 1);
        check("req0_ready", W'(req0_ready), W'(exp0));
        check("req1_ready", W'(req1_ready), W'(exp1));
        check("rsp_valid", W'(rsp_valid), W'(exp_v));
        if (m_in_exec) begin
          check("exec_alu_signal", W'(alu_signal), W'(m_cur.op));
          check("exec_alu_a", alu_a, m_cur.a);
          check("exec_alu_b", alu_b, m_cur.b);
        end
        if (prev_valid && !prev_hs) begin
          check("hold_rsp_id", W'(rsp_id), W'(prev_id));
          check("hold_rsp_data", rsp_data, prev_data);
          check("hold_rsp_err", W'(rsp_err), W'(prev_err));
        end
        if (rsp_valid && rsp_ready) begin
          if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got id %0d data %0h with no outstanding request", rsp_id, rsp_data);
          end else begin
            e = expq.pop_front();
            check("rsp_id", W'(rsp_id), W'(e.id));
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", W'(rsp_err), W'(e.err));
          end
        end
        prev_valid = rsp_valid; prev_hs = rsp_valid && rsp_ready;
        prev_id = rsp_id; prev_data = rsp_data; prev_err = rsp_err;
        got0 = req0_valid && req0_ready;
        got1 = req1_valid && req1_ready;
        if (m_busy && m_wait > 0) m_wait--;
        if (exp_v && rsp_ready) begin
          m_busy = 0;
          m_ptr = ~m_cur_id;
        end
        if (exp0 || exp1) begin
          m_cur_id = exp1;
          m_cur = exp1 ? mk(req1_op, req1_a, req1_b) : mk(req0_op, req0_a, req0_b);
          e.id = exp1;
          e.err = !is_legal(m_cur.op);
          e.data = e.err ? '0 : alu_fn(m_cur.op, m_cur.a, m_cur.b);
          expq.push_back(e);
          m_busy = 1;
          m_wait = e.err ? 0 : 1;
        end
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst_n = 0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #2 model_reset();
    rst_n = 1;
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    int c;
    legal_ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL};
    #1 check_zero("por");
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    // Single ADD with the consumer always ready.
    rsp_fixed = 1;
    q0.push_back(mk(OP_ADD, 32'd5, 32'd7));
    drain("add", 50);

    // Both requesters continuously valid straight after reset.
    pulse_reset();
    q0.push_back(mk(OP_SUB, 32'd9, 32'd4));
    q1.push_back(mk(OP_SLT, 32'd3, 32'd8));
    q0.push_back(mk(OP_SUB, 32'd9, 32'd4));
    q1.push_back(mk(OP_SLT, 32'd3, 32'd8));
    drain("rr", 100);

    // Unsupported function code.
    q1.push_back(mk(6'b111111, 32'h1234_5678, 32'h9ABC_DEF0));
    drain("illegal", 50);

    // Consumer stalls 5 cycles while another request waits.
    rsp_fixed = 0;
    q0.push_back(mk(OP_ADD, 32'd100, 32'd23));
    c = 0;
    while (!rsp_valid && c < 50) begin @(negedge clk); #1; c++; end
    check("stall_rsp_seen", W'(rsp_valid), 32'd1);
    q0.push_back(mk(OP_SUB, 32'd50, 32'd8));
    repeat (5) @(negedge clk);
    #1 rsp_fixed = 1;
    drain("stall", 100);

    // Reset while AND is executing, with another AND queued behind it.
    q0.push_back(mk(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F));
    q0.push_back(mk(OP_AND, 32'd3, 32'd6));
    c = 0;
    do begin @(negedge clk); #1; c++; end while (!m_in_exec && c < 50);
    check("exec_reached", W'(m_in_exec), 32'd1);
    rst_n = 0;
    #1 check_zero("exec_reset");
    repeat (2) @(posedge clk);
    #2 model_reset();
    rst_n = 1;
    drain("post_reset", 100);

    q0.push_back(mk(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F));
    drain("or", 50);

    // Randomised traffic with withdrawals and a bursty consumer.
    withdraw_en = 1;
    rsp_rand = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(99) < 40) begin
        op = ($urandom_range(7) < 6) ? legal_ops[$urandom_range(5)] : 6'($urandom);
        if ($urandom_range(1) == 0) begin
          if (q0.size() < 3) q0.push_back(mk(op, $urandom, ($urandom_range(1) != 0) ? 32'($urandom_range(40)) : $urandom));
        end else begin
          if (q1.size() < 3) q1.push_back(mk(op, $urandom, ($urandom_range(1) != 0) ? 32'($urandom_range(40)) : $urandom));
        end
      end
    end
    drain("random", 3000);
    withdraw_en = 0;
    rsp_rand = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1);
  end
endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
- REQ-001 SHALL have parameter W, default 32, the operand/result width in bits.
- REQ-002 SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-003 SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have `req0_valid`, input, 1 bit: requester 0 presents an operation.
- REQ-005 SHALL have `req0_ready`, output, 1 bit: requester 0 operation accepted this cycle.
- REQ-006 SHALL have `req0_op`, input, 6 bits: function code.
- REQ-007 SHALL have `req0_a` and `req0_b`, input, W bits each: operands.
- REQ-008 SHALL have the same five ports for requester 1 as `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`.
- REQ-009 SHALL have `rsp_valid`, output, 1 bit: result available.
- REQ-010 SHALL have `rsp_ready`, input, 1 bit: consumer accepts result.
- REQ-011 SHALL have `rsp_id`, output, 1 bit: index of the requester the result belongs to.
- REQ-012 SHALL have `rsp_data`, output, W bits: result.
- REQ-013 SHALL have `rsp_err`, output, 1 bit: unsupported function code.
- REQ-014 SHALL have `alu_signal`, output, 6 bits: function code to the shared ALU.
- REQ-015 SHALL have `alu_a` and `alu_b`, output, W bits each: operands to the shared ALU.
- REQ-016 SHALL have `alu_result`, input, W bits: combinational ALU output.

Function
- REQ-017 SHALL treat as legal only the codes AND=100100, OR=100101, ADD=100000, SUB=100010, SLT=101010, SRL=000010; every other code is illegal.
- REQ-018 SHALL implement a 3-state FSM with states IDLE, EXEC and RESP.
- REQ-019 In IDLE with at least one valid request, SHALL grant one requester, assert only that requester's ready combinationally in the same cycle, and register its op, a, b and id.
- REQ-020 Arbitration SHALL be round-robin using a 1-bit priority pointer.
  - A lone valid requester always wins.
  - When both are valid, the pointer's requester wins.
  - The pointer SHALL move to the other requester when the granted response completes.
- REQ-021 A grant of a legal op SHALL move IDLE to EXEC.
- REQ-022 A grant of an illegal op SHALL move IDLE directly to RESP with rsp_data=0 and rsp_err=1; the ALU SHALL NOT be used.
- REQ-023 alu_signal, alu_a and alu_b SHALL be driven from the captured registers at all times.
- REQ-024 alu_result SHALL be sampled only at the EXEC clock edge; EXEC always lasts exactly 1 cycle and then moves to RESP.
- REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_id, rsp_data and rsp_err SHALL stay stable until rsp_ready=1.
- REQ-026 rsp_valid & rsp_ready SHALL return the FSM to IDLE on that edge.
- REQ-027 Latency SHALL be as follows:
  - Legal op accepted at edge N: rsp_valid from edge N+1, with the result captured at edge N+1 and visible after it.
  - Illegal op: rsp_valid visible after edge N.
  - Next acceptance no earlier than the cycle after rsp handshake.
- REQ-028 reqX_ready SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait without being lost.
- REQ-029 Requester valid/op/operands need not be held after the ready cycle.
- REQ-030 rsp_ready while rsp_valid=0 SHALL be ignored.
- REQ-031 Deasserting a valid before it is granted SHALL withdraw that request with no side effect.

Reset
- REQ-032 While rst_n=0, SHALL asynchronously force:
  - state = IDLE and pointer = 0 (requester 0 favoured);
  - rsp_valid, rsp_id, rsp_err, rsp_data = 0;
  - alu_signal, alu_a, alu_b = 0;
  - req0_ready, req1_ready = 0.
- REQ-033 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response appears after reset release.
- REQ-034 After reset release, the first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
- REQ-035 Bench SHALL cover: req0 ADD a=5, b=7, rsp_ready=1 -> ready0 pulses 1 cycle; rsp_valid 2 edges later; rsp_id=0, rsp_data=12, rsp_err=0; alu_signal=100000 during EXEC.
- REQ-036 Bench SHALL cover: both valid continuously after reset, req0 SUB 9-4, req1 SLT 3,8 -> grants alternate 0,1,0,1; rsp_data 5 (id 0) then 1 (id 1).
- REQ-037 Bench SHALL cover: req1 op=111111 -> rsp_valid 1 edge after accept; rsp_err=1; rsp_data=0; rsp_id=1.
- REQ-038 Bench SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/data stable throughout; ready0/1 stay 0; a pending req0 is granted the cycle after the handshake.
- REQ-039 Bench SHALL cover: rst_n pulled low mid-EXEC with req0 AND pending -> all outputs 0 immediately; no response after release; the next request is granted normally.
- REQ-040 Bench SHALL cover: req0 OR 0xF0F0_0000 | 0x0000_0F0F while ALU model active -> rsp_data=0xF0F0_0F0F.
